mmio_flag_unit: RTL
===================

Name: mmio_flag_unit

Overview:
- Parametrised memory-mapped flag/mailbox block on the CPU store bus, next to the single-cycle core top.
- Generalises the single hard-coded "store to one address" flag to NUM_CH channels at a configurable base address.
- Each channel adds a data latch, a sticky flag and a saturating write counter.
- Provides a registered read-back port so software and testbenches can poll status.

Parameters:
- BASE_ADDR, 32'h02000000, word-aligned base of the register window
- NUM_CH, 4, number of channels (1..16)
- CNT_W, 16, width of each per-channel write counter (2..32)

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- MemWrite  input  1  store strobe from core
- Mem_WrAddr  input  32  store byte address
- Mem_WrData  input  32  store data
- Rd_En  input  1  read request
- Rd_Addr  input  32  read byte address
- Rd_Data  output  32  read data, registered
- Rd_Valid  output  1  high one cycle after an accepted Rd_En
- hit  output  NUM_CH  combinational per-channel write-hit decode (hit[2] equals the legacy single-address flag at BASE+8)
- flag_pulse  output  NUM_CH  registered one-cycle pulse per channel write
- flag_sticky  output  NUM_CH  sticky per-channel flag
- sticky_clr  input  NUM_CH  external clear of sticky bits
- irq  output  1  interrupt, see Optional Feature

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Register map (word offsets from BASE_ADDR):
  - 4*i: CH_DATA[i], for i < NUM_CH
  - 4*NUM_CH: STATUS. Read returns the sticky bits, zero-extended. Write is write-1-to-clear.
  - 4*NUM_CH+4: IRQ_MASK (optional)
  - 0x40+4*i: CH_CNT[i], read-only, zero-extended
- Decode rules: an access decodes only if Mem_WrAddr[1:0]==0 and the address falls in a mapped slot. Unaligned or unmapped writes are ignored. Unaligned or unmapped reads return 0 with Rd_Valid still asserted.
- hit[i] = MemWrite && (Mem_WrAddr == BASE_ADDR+4*i). It is purely combinational, with zero latency.
- On a rising edge with hit[i]:
  - CH_DATA[i] <= Mem_WrData
  - sticky[i] <= 1
  - CH_CNT[i] increments, saturating at all-ones with no wrap
  - flag_pulse[i] = 1 for exactly the next cycle. Back-to-back writes keep it high on consecutive cycles.
- STATUS write: sticky[i] clears where Mem_WrData[i]==1. sticky_clr[i] also clears sticky[i].
- Set priority: set beats clear in the same cycle. A hit[i] simultaneous with a STATUS write clearing bit i, or with sticky_clr[i], leaves sticky[i]=1.
- Counters are read-only. Writes to the CH_CNT addresses are ignored.
- Read path, one-cycle latency:
  - Rd_En sampled at edge N gives Rd_Data and Rd_Valid=1 after edge N.
  - Rd_Valid is 0 in cycles without a preceding Rd_En.
  - Rd_Data holds its last value when Rd_Valid is 0.
  - A read and a write to the same register in the same cycle return the pre-write (old) value.
- Reset values: CH_DATA=0, CH_CNT=0, sticky=0, flag_pulse=0, Rd_Data=0, Rd_Valid=0, IRQ_MASK=0, irq=0.
- Reset mid-operation: reset wins over any same-cycle write. A pulse in flight is dropped, so flag_pulse is 0 on the cycle after the reset edge.
- Only one store per cycle exists, so at most one hit bit is high at a time.

Optional Feature:
- MMIO_IRQ_EN defined:
  - IRQ_MASK register exists, NUM_CH bits, read/write.
  - irq is registered: irq <= |(sticky & IRQ_MASK).
  - irq rises one cycle after sticky rises on an unmasked channel. It falls one cycle after the clear or the unmask.
- MMIO_IRQ_EN undefined:
  - irq tied to 0.
  - The IRQ_MASK address is treated as unmapped: writes are ignored, reads return 0.

Test Plan:
- Reset check: assert reset 2 cycles -> all outputs 0 and all counters read 0.
- Legacy flag: store 0xDEADBEEF to 0x02000008 -> hit[2]=1 in the same cycle. Next cycle: flag_pulse=4'b0100, flag_sticky[2]=1, read of 0x02000008 returns 0xDEADBEEF with Rd_Valid one cycle after Rd_En.
- Counter saturation: CNT_W=2, 5 stores to 0x02000000 -> CH_CNT[0] reads 3. flag_pulse[0] high for 5 consecutive cycles.
- W1C and set priority: sticky=4'b1111, then store 0x5 to STATUS (0x02000010) -> sticky=4'b1010. Then STATUS write 0x2 together with a hit on channel 1 -> sticky[1] stays 1.
- Unmapped and unaligned: store to 0x02000009 and to 0x02000030 -> no state change. Read of 0x02000030 -> Rd_Data=0, Rd_Valid=1.
- MMIO_IRQ_EN: set IRQ_MASK=0x4, store to channel 2 -> irq=1 two cycles after the store edge. Clear via sticky_clr[2] -> irq=0 one cycle later. With the macro undefined, irq stays 0 throughout.

Source files
------------

// File: rtl/mmio_flag_unit.sv
// Memory-mapped flag/mailbox block: per-channel data latch, sticky flag and saturating write counter.
// Optional interrupt mask register and registered irq when MMIO_IRQ_EN is defined.

module mmio_flag_ch #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hit,
  input  logic [31:0]      wr_data,
  input  logic             clr,
  output logic [31:0]      data,
  output logic             sticky,
  output logic             pulse,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (reset) begin
      data   <= '0;
      sticky <= 1'b0;
      pulse  <= 1'b0;
      cnt    <= '0;
    end else begin
      pulse  <= hit;
      // a set in the same cycle as a clear leaves the flag set
      sticky <= hit | (sticky & ~clr);
      if (hit) begin
        data <= wr_data;
        if (cnt != '1) cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

module mmio_flag_unit #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          NUM_CH    = 4,
  parameter int          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWrite,
  input  logic [31:0]       Mem_WrAddr,
  input  logic [31:0]       Mem_WrData,
  input  logic              Rd_En,
  input  logic [31:0]       Rd_Addr,
  output logic [31:0]       Rd_Data,
  output logic              Rd_Valid,
  output logic [NUM_CH-1:0] hit,
  output logic [NUM_CH-1:0] flag_pulse,
  output logic [NUM_CH-1:0] flag_sticky,
  input  logic [NUM_CH-1:0] sticky_clr,
  output logic              irq
);
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'(4*NUM_CH);
  localparam logic [31:0] MASK_ADDR   = STATUS_ADDR + 32'd4;
  localparam logic [31:0] CNT_BASE    = BASE_ADDR + 32'h40;

  logic [NUM_CH-1:0][31:0]      ch_data;
  logic [NUM_CH-1:0][CNT_W-1:0] ch_cnt;
  logic [NUM_CH-1:0]            clr;
  logic                         status_wr;
  logic [31:0]                  rd_next;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_CH; i++)
      hit[i] = MemWrite && (Mem_WrAddr == BASE_ADDR + 32'(4*i));
  end

  assign status_wr = MemWrite && (Mem_WrAddr == STATUS_ADDR);
  assign clr       = sticky_clr | ({NUM_CH{status_wr}} & Mem_WrData[NUM_CH-1:0]);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    mmio_flag_ch #(.CNT_W(CNT_W)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .hit     (hit[g]),
      .wr_data (Mem_WrData),
      .clr     (clr[g]),
      .data    (ch_data[g]),
      .sticky  (flag_sticky[g]),
      .pulse   (flag_pulse[g]),
      .cnt     (ch_cnt[g])
    );
  end

`ifdef MMIO_IRQ_EN
  logic [NUM_CH-1:0] irq_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      if (MemWrite && (Mem_WrAddr == MASK_ADDR)) irq_mask <= Mem_WrData[NUM_CH-1:0];
      irq <= |(flag_sticky & irq_mask);
    end
  end
`else
  assign irq = 1'b0;
`endif

  // Later matches win, so data/status/mask take the slot if NUM_CH is large enough to overlap CH_CNT.
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (Rd_Addr == CNT_BASE + 32'(4*i)) rd_next = 32'(ch_cnt[i]);
    for (int i = 0; i < NUM_CH; i++)
      if (Rd_Addr == BASE_ADDR + 32'(4*i)) rd_next = ch_data[i];
    if (Rd_Addr == STATUS_ADDR) rd_next = 32'(flag_sticky);
`ifdef MMIO_IRQ_EN
    if (Rd_Addr == MASK_ADDR) rd_next = 32'(irq_mask);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Rd_Data  <= '0;
      Rd_Valid <= 1'b0;
    end else begin
      Rd_Valid <= Rd_En;
      if (Rd_En) Rd_Data <= rd_next;
    end
  end
endmodule
